// File: rtl/pkg_resultQueue.sv
// Result-queue shared constants.
//   WIDTH : width of one result word carried through the queue.
package pkg_resultQueue;
  parameter int unsigned WIDTH = 32;
endpackage

// File: rtl/structs.sv
// Result-queue write-side interface bundles.
//   struct_resultQueue_Write_In  : loader -> queue (we, d)
//   struct_resultQueue_Write_Out : queue -> loader (full)
package structs;
  typedef struct packed {
    logic                              we;
    logic [pkg_resultQueue::WIDTH-1:0] d;
  } struct_resultQueue_Write_In;

  typedef struct packed {
    logic full;
  } struct_resultQueue_Write_Out;
endpackage

// File: rtl/result_queue_loader.sv
// result_queue_loader
// Takes result words from the compute block over a valid/accepted handshake, registers each
// word and pushes it into the result queue, waiting while the queue reports full. Pushed words
// are counted per frame, and a one-cycle frame_done strobe follows every FRAME_LEN-th push.
//
// Ports:
//   clk           : clock, rising edge
//   resetn        : synchronous active-low reset
//   data_valid    : producer has a word on data (held until data_accepted)
//   data_accepted : one-cycle pulse, word on data captured this cycle
//   data          : result word from producer
//   frame_cnt     : words pushed in the current frame
//   frame_done    : one-cycle pulse after the last push of a frame
//   rqw_in        : queue write request (we, d)
//   rqw_out       : queue write status (full)
module result_queue_loader #(
  parameter int unsigned  FRAME_LEN = 16,
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 data_valid,
  output logic                                 data_accepted,
  input  logic [pkg_resultQueue::WIDTH-1:0]    data,
  output logic [CNT_W-1:0]                     frame_cnt,
  output logic                                 frame_done,
  output structs::struct_resultQueue_Write_In  rqw_in,
  input  structs::struct_resultQueue_Write_Out rqw_out
);

  typedef enum logic [2:0] {
    StReset     = 3'd0,
    StIdle      = 3'd1,
    StCapture   = 3'd2,
    StCheckFull = 3'd3,
    StPush      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(FRAME_LEN - 1);

  state_e                            state_q, state_d;
  logic [pkg_resultQueue::WIDTH-1:0] hold_q;
  logic [CNT_W-1:0]                  frame_cnt_q;
  logic                              frame_done_q;

  always_comb begin
    state_d = StReset;
    case (state_q)
      StReset:     state_d = StIdle;
      StIdle:      state_d = data_valid ? StCapture : StIdle;
      StCapture:   state_d = StCheckFull;
      // full can only fall while we wait: this block is the queue's only writer.
      StCheckFull: state_d = rqw_out.full ? StCheckFull : StPush;
      StPush:      state_d = StIdle;
      default:     state_d = StReset;
    endcase
    if (!resetn) begin
      state_d = StReset;
    end
  end

  // Clearing on any entry to StReset (reset or illegal encoding) keeps every output at zero
  // there. Reset also wins over a push in the same cycle: the word is written, the count is not.
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    frame_done_q <= 1'b0;
    if (state_d == StReset) begin
      hold_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (state_q == StCapture) begin
        hold_q <= data;
      end
      if (state_q == StPush) begin
        if (frame_cnt_q == LastCnt) begin
          frame_cnt_q  <= '0;
          frame_done_q <= 1'b1;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    data_accepted = (state_q == StCapture);
    rqw_in.we     = (state_q == StPush);
    rqw_in.d      = hold_q;
    frame_cnt     = frame_cnt_q;
    frame_done    = frame_done_q;
  end

endmodule

// File: doc/result_queue_loader.md
Name: result_queue_loader

Overview:
- Write-side counterpart of the result-queue reader.
- Accepts result words from the producing compute block through a valid/accepted handshake.
- Registers each word and pushes it into the result queue through the queue write interface, stalling while the queue is full.
- Counts pushed words per frame and pulses a frame-done strobe after every FRAME_LEN words, so the controller knows a full result set is queued.

Parameters:
FRAME_LEN, 16, number of pushed words per frame; legal range 1..65535
CNT_W, $clog2(FRAME_LEN+1), width of the frame counter (derived; do not override)

Ports:
clk  input  1  clock; all logic on rising edge
resetn  input  1  reset, synchronous, active-low
data_valid  input  1  producer has a word on data; held until data_accepted seen
data_accepted  output  1  one-cycle pulse; word on data captured this cycle
data  input  pkg_resultQueue::WIDTH  result word from producer
frame_cnt  output  CNT_W  words pushed in current frame
frame_done  output  1  one-cycle pulse after the FRAME_LEN-th push of a frame
rqw_in  output  structs::struct_resultQueue_Write_In  queue write request: we (1), d (WIDTH)
rqw_out  input  structs::struct_resultQueue_Write_Out  queue write status: full (1)

Behaviour:
- Reset: synchronous. When resetn is sampled low, the next state is S_Reset, the hold register is cleared, frame_cnt goes to 0 and frame_done goes to 0.
- While in S_Reset, all outputs are 0: data_accepted=0, rqw_in.we=0, rqw_in.d=0, frame_cnt=0, frame_done=0.
- State register: CurState <= NextState every edge. NextState is forced to S_Reset whenever resetn=0, regardless of the current state.
- States and transitions:
  - S_Reset -> S_Idle.
  - S_Idle -> S_Capture if data_valid, else stays in S_Idle.
  - S_Capture -> S_CheckFull. In this state data_accepted=1 and hold_q <= data.
  - S_CheckFull -> S_Push if !rqw_out.full, else stays in S_CheckFull.
  - S_Push -> S_Idle. In this state rqw_in.we=1.
  - Any illegal encoding -> S_Reset.
- Outputs are decoded from CurState only:
  - data_accepted = (CurState==S_Capture).
  - rqw_in.we = (CurState==S_Push).
  - rqw_in.d = hold_q at all times.
- Handshake rules:
  - The producer keeps data and data_valid stable until it samples data_accepted=1.
  - It may present the next word starting the cycle after that.
  - A word is never captured twice: at least 2 cycles separate S_Capture from the next S_Idle.
- Throughput:
  - Minimum 4 cycles per word (Idle, Capture, CheckFull, Push).
  - Latency from data_valid rising in S_Idle to we is 3 cycles when the queue is not full.
- Full handling:
  - full is sampled only in S_CheckFull.
  - This block is the sole writer and the reader only lowers occupancy, so full cannot rise between S_CheckFull and S_Push.
  - we is never asserted while full=1.
- Frame counter:
  - On each S_Push cycle, if frame_cnt==FRAME_LEN-1: frame_cnt <= 0 and frame_done <= 1.
  - Otherwise on each S_Push cycle: frame_cnt <= frame_cnt+1.
  - frame_done is registered and is 1 for exactly the cycle after the final push; it is 0 in all other cycles.
  - FRAME_LEN=1 gives a frame_done pulse after every push.
- Reset mid-operation:
  - If resetn goes low during S_Push, we is still 1 in that cycle and the word is written (CurState-decoded). frame_cnt is still cleared, because reset has priority over the increment.
  - A word held in S_CheckFull is discarded with no write.
  - The producer must re-present any word it was not told was accepted.
- Data is never modified; rqw_in.d is bit-exact with data as sampled in S_Capture.

Test Plan:
- Reset, then resetn=1 with queue empty and data_valid=1, data=0xA5 held:
  - data_accepted pulses at cycle 2 after S_Idle entry.
  - we=1 with d=0xA5 exactly 2 cycles later.
  - frame_cnt becomes 1.
- full=1 held for 10 cycles while a word 0x3C is captured:
  - Block stays in S_CheckFull and we remains 0 throughout.
  - After full drops, exactly one we pulse with d=0x3C; no word is lost or duplicated.
- FRAME_LEN=4, stream words 1..9 with data_valid continuously high:
  - Nine we pulses, in order, spaced every 4 cycles.
  - frame_done pulses once after the 4th push and once after the 8th push.
  - frame_cnt ends at 1.
- resetn pulled low while in S_CheckFull holding 0x77:
  - No write of 0x77 occurs.
  - frame_cnt=0 and all outputs are 0 the next cycle.
  - Normal operation resumes 1 cycle after resetn returns high.
- Random producer gaps plus random full toggling for 2000 words:
  - Scoreboard shows the queue-side sequence equals the producer-side sequence.
  - we&&full is never true.
  - frame_done count equals floor(2000/FRAME_LEN).
